// File: rtl/traffic_sensor_conditioner_if.sv
// Signal bundle between the loop-detector front end and the light controller.
// Optional vehicle counters are controlled by the TRAFFIC_COUNT_EN macro in the design file.
interface traffic_sensor_conditioner_if;
  // All members are plain levels sampled on the rising clock edge.
  // There is no valid/ready handshake: a raw line may change at any time,
  // and a traffic request is held for as long as the level is asserted.
  logic       sensor_A_raw;
  logic       sensor_B_raw;
  logic       cnt_clr;
  logic       traffic_A;
  logic       traffic_B;
  logic [7:0] veh_cnt_A;
  logic [7:0] veh_cnt_B;

  modport master (
    output sensor_A_raw, sensor_B_raw, cnt_clr,
    input  traffic_A, traffic_B, veh_cnt_A, veh_cnt_B
  );

  modport slave (
    input  sensor_A_raw, sensor_B_raw, cnt_clr,
    output traffic_A, traffic_B, veh_cnt_A, veh_cnt_B
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Two-channel loop-detector conditioner: synchronize, debounce, bridge short gaps.
// Define TRAFFIC_COUNT_EN to build the saturating per-channel vehicle counters.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_A_raw,
  input  logic       sensor_B_raw,
  input  logic       cnt_clr,
  output logic       traffic_A,
  output logic       traffic_B,
  output logic [7:0] veh_cnt_A,
  output logic [7:0] veh_cnt_B,
  output logic [3:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] raw_w;
  logic [1:0] traffic_w;
  logic [1:0] inc_w;

  assign raw_w = {sensor_B_raw, sensor_A_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic       sync1_q;
    logic       sync2_q;
    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       traffic_q;
    logic       traffic_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_w[g];
        sync2_q <= sync1_q;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= IDLE;
        cnt_q     <= 8'd0;
        traffic_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        traffic_q <= traffic_d;
      end
    end

    // cnt counts consecutive high samples in ARMING and low samples in HOLD.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_d = ARMING;
            cnt_d   = 8'd1;
          end
        end
        ARMING: begin
          if (!sync2_q) begin
            state_d = IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ACTIVE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ACTIVE: begin
          if (!sync2_q) begin
            state_d = HOLD;
            cnt_d   = 8'd1;
          end
        end
        HOLD: begin
          if (sync2_q) begin
            state_d = ACTIVE;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end

    // Output is decoded from the next state so the register tracks the state exactly.
    always_comb begin
      traffic_d = (state_d == ACTIVE) || (state_d == HOLD);
      inc_w[g]  = (state_q == ARMING) && (state_d == ACTIVE);
    end

    assign traffic_w[g]          = traffic_q;
    assign state_dbg_o[2*g +: 2] = state_q;
  end

  assign traffic_A = traffic_w[0];
  assign traffic_B = traffic_w[1];

`ifdef TRAFFIC_COUNT_EN
  logic [7:0] veh_q [2];
  logic [7:0] veh_d [2];

  // Clear wins over a same-cycle new vehicle; the count sticks at 255.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      veh_d[i] = veh_q[i];
      if (cnt_clr) begin
        veh_d[i] = 8'd0;
      end else if (inc_w[i] && (veh_q[i] != 8'hFF)) begin
        veh_d[i] = veh_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      veh_q[0] <= 8'd0;
      veh_q[1] <= 8'd0;
    end else begin
      veh_q[0] <= veh_d[0];
      veh_q[1] <= veh_d[1];
    end
  end

  assign veh_cnt_A = veh_q[0];
  assign veh_cnt_B = veh_q[1];
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = cnt_clr ^ (^inc_w);
  assign veh_cnt_A         = 8'd0;
  assign veh_cnt_B         = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: directed vector table,
// multi-cycle corner sequences and randomized traffic against a run-length model.
module tb_traffic_sensor_conditioner;
  localparam int DEB = 4;
  localparam int HLD = 8;
`ifdef TRAFFIC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] state_dbg;

  traffic_sensor_conditioner_if bus ();

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_A_raw(bus.sensor_A_raw),
    .sensor_B_raw(bus.sensor_B_raw),
    .cnt_clr     (bus.cnt_clr),
    .traffic_A   (bus.traffic_A),
    .traffic_B   (bus.traffic_B),
    .veh_cnt_A   (bus.veh_cnt_A),
    .veh_cnt_B   (bus.veh_cnt_B),
    .state_dbg_o (state_dbg)
  );

  // ---------------- reference model ----------------
  // Per channel: the sample seen at an edge is the raw level two edges earlier.
  // Traffic rises after DEB consecutive high samples and falls after HLD
  // consecutive low samples; each rise is one vehicle.
  typedef struct {
    bit d1;
    bit d2;
    int hi;
    int lo;
    bit tr;
    int cnt;
  } ch_t;

  ch_t m_a;
  ch_t m_b;

  function automatic ch_t step(ch_t c, bit raw, bit clr);
    ch_t n;
    bit  s;
    n    = c;
    s    = c.d2;
    n.d2 = c.d1;
    n.d1 = raw;
    if (!c.tr) begin
      n.hi = s ? c.hi + 1 : 0;
      if (n.hi >= DEB) begin
        n.tr = 1'b1;
        n.hi = 0;
        n.lo = 0;
        if (CNT_EN && c.cnt < 255) n.cnt = c.cnt + 1;
      end
    end else begin
      n.lo = s ? 0 : c.lo + 1;
      if (n.lo >= HLD) begin
        n.tr = 1'b0;
        n.lo = 0;
      end
    end
    if (CNT_EN && clr) n.cnt = 0;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a <= '{default: 0};
      m_b <= '{default: 0};
    end else begin
      m_a <= step(m_a, bus.sensor_A_raw, bus.cnt_clr);
      m_b <= step(m_b, bus.sensor_B_raw, bus.cnt_clr);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ec(input int x);
    return CNT_EN ? x : 0;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: inputs change after the falling edge, checks happen on it.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("mdl_traffic_A", bus.traffic_A, m_a.tr);
    check("mdl_traffic_B", bus.traffic_B, m_b.tr);
    check("mdl_veh_cnt_A", bus.veh_cnt_A, m_a.cnt);
    check("mdl_veh_cnt_B", bus.veh_cnt_B, m_b.cnt);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_outputs(input string tag, input bit ta, input bit tb,
                               input int ca, input int cb);
    check({tag, "_traffic_A"}, bus.traffic_A, ta);
    check({tag, "_traffic_B"}, bus.traffic_B, tb);
    check({tag, "_veh_cnt_A"}, bus.veh_cnt_A, ec(ca));
    check({tag, "_veh_cnt_B"}, bus.veh_cnt_B, ec(cb));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit a;
    bit b;
    int n;
    bit ta;
    bit tb;
    int ca;
    int cb;
  } vec_t;

  vec_t vt[11];

  initial begin
    int a_left;
    int b_left;

    // Hold levels for n cycles, then expect these outputs after the last edge.
    vt[0]  = '{a: 0, b: 0, n: 20, ta: 0, tb: 0, ca: 0, cb: 0};  // idle after reset
    vt[1]  = '{a: 1, b: 0, n: 3,  ta: 0, tb: 0, ca: 0, cb: 0};  // 3-cycle glitch
    vt[2]  = '{a: 0, b: 0, n: 10, ta: 0, tb: 0, ca: 0, cb: 0};  // glitch rejected
    vt[3]  = '{a: 1, b: 0, n: 5,  ta: 0, tb: 0, ca: 0, cb: 0};  // one edge early
    vt[4]  = '{a: 1, b: 0, n: 1,  ta: 1, tb: 0, ca: 1, cb: 0};  // rise after edge 6
    vt[5]  = '{a: 0, b: 0, n: 9,  ta: 1, tb: 0, ca: 1, cb: 0};  // still held
    vt[6]  = '{a: 0, b: 0, n: 1,  ta: 0, tb: 0, ca: 1, cb: 0};  // fall after edge 10
    vt[7]  = '{a: 0, b: 1, n: 6,  ta: 0, tb: 1, ca: 1, cb: 1};  // B vehicle
    vt[8]  = '{a: 0, b: 0, n: 5,  ta: 0, tb: 1, ca: 1, cb: 1};  // 5-cycle gap
    vt[9]  = '{a: 0, b: 1, n: 20, ta: 0, tb: 1, ca: 1, cb: 1};  // bridged, no count
    vt[10] = '{a: 1, b: 1, n: 6,  ta: 1, tb: 1, ca: 2, cb: 1};  // both active

    // Reset asserted with raw lines high.
    bus.sensor_A_raw = 1'b1;
    bus.sensor_B_raw = 1'b1;
    bus.cnt_clr      = 1'b0;
    reset            = 1'b0;
    run(3);
    check_outputs("in_reset", 0, 0, 0, 0);
    check("in_reset_state", state_dbg, 0);

    bus.sensor_A_raw = 1'b0;
    bus.sensor_B_raw = 1'b0;
    #2 reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      bus.sensor_A_raw = vt[i].a;
      bus.sensor_B_raw = vt[i].b;
      run(vt[i].n);
      check_outputs($sformatf("vec%0d", i), vt[i].ta, vt[i].tb, vt[i].ca, vt[i].cb);
    end

    // Both channels into HOLD, then asynchronous reset between edges.
    bus.sensor_A_raw = 1'b0;
    bus.sensor_B_raw = 1'b0;
    run(4);
    check_outputs("hold_both", 1, 1, 2, 1);
    check("hold_both_state", state_dbg, 4'b1111);
    #2 reset = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0);
    check("async_rst_state", state_dbg, 0);
    run(3);
    #2 reset = 1'b1;
    run(20);
    check_outputs("post_rst", 0, 0, 0, 0);

    // 300 valid A vehicles of random length saturate the counter.
    for (int v = 0; v < 300; v++) begin
      bus.sensor_A_raw = 1'b1;
      run($urandom_range(DEB + 2, DEB + 6));
      bus.sensor_A_raw = 1'b0;
      run($urandom_range(HLD + 2, HLD + 5));
    end
    check_outputs("saturate", 0, 0, 255, 0);

    // Clear lands on the same edge as a new vehicle's ARMING->ACTIVE.
    bus.sensor_A_raw = 1'b1;
    run(DEB + 1);
    bus.cnt_clr = 1'b1;
    run(1);
    bus.cnt_clr = 1'b0;
    check_outputs("clr_vs_inc", 1, 0, 0, 0);
    bus.sensor_A_raw = 1'b0;
    run(HLD + 4);
    check_outputs("clr_after", 0, 0, 0, 0);

    // Randomized independent run lengths on both lines, occasional clear.
    a_left = 0;
    b_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (a_left == 0) begin
        bus.sensor_A_raw = ~bus.sensor_A_raw;
        a_left = $urandom_range(1, 14);
      end
      if (b_left == 0) begin
        bus.sensor_B_raw = ~bus.sensor_B_raw;
        b_left = $urandom_range(1, 14);
      end
      bus.cnt_clr = ($urandom_range(0, 127) == 0);
      a_left--;
      b_left--;
      tick();
    end
    bus.cnt_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive high samples needed to declare traffic (legal 2..15).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, consecutive low samples needed to drop traffic (legal 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sensor_A_raw  input  1  asynchronous loop-detector line, Academic approach.
REQ-006 SHALL have port sensor_B_raw  input  1  asynchronous loop-detector line, Bravado approach.
REQ-007 SHALL have port cnt_clr  input  1  synchronous clear of both vehicle counters.
REQ-008 SHALL have port traffic_A  output  1  conditioned traffic request that drives the light controller's traffic_A input.
REQ-009 SHALL have port traffic_B  output  1  conditioned traffic request that drives the light controller's traffic_B input.
REQ-010 SHALL have port veh_cnt_A  output  8  saturating vehicle count, Academic.
REQ-011 SHALL have port veh_cnt_B  output  8  saturating vehicle count, Bravado.

Function
REQ-012 SHALL pass each raw input through its own 2-flop synchronizer; the second-stage output is the sample s used below.
REQ-013 SHALL run one independent FSM per channel with states IDLE, ARMING, ACTIVE and HOLD, plus an 8-bit counter cnt per channel.
REQ-014 SHALL, in IDLE with s=1, go to ARMING with cnt=1; with s=0, stay in IDLE.
REQ-015 SHALL, in ARMING with s=0, go to IDLE; with s=1 and cnt=DEBOUNCE_CYCLES-1, go to ACTIVE; otherwise increment cnt.
REQ-016 SHALL, in ACTIVE with s=0, go to HOLD with cnt=1; with s=1, stay in ACTIVE.
REQ-017 SHALL, in HOLD with s=1, return to ACTIVE; with s=0 and cnt=HOLD_CYCLES-1, go to IDLE; otherwise increment cnt.
REQ-018 SHALL drive traffic_X as a registered Moore output: 1 in ACTIVE and HOLD, 0 in IDLE and ARMING.
REQ-019 Rise latency SHALL be as follows: a raw rise stable from before edge 1 gives traffic_X=1 after edge 2+DEBOUNCE_CYCLES.
REQ-020 Fall latency SHALL be as follows: a raw fall stable from before edge 1 gives traffic_X=0 after edge 2+HOLD_CYCLES.
REQ-021 SHALL filter out any raw high pulse shorter than DEBOUNCE_CYCLES samples: no traffic_X change and no count.
REQ-022 SHALL let any low gap shorter than HOLD_CYCLES samples during ACTIVE/HOLD pass without traffic_X deasserting.
REQ-023 SHALL keep the channels fully independent; simultaneous activity on A and B needs no arbitration.
REQ-024 SHALL increment veh_cnt_X only on an ARMING->ACTIVE transition; HOLD->ACTIVE re-entry SHALL NOT count.
REQ-025 SHALL saturate veh_cnt_X at 255, with no wrap-around.
REQ-026 SHALL let cnt_clr=1 force both counters to 0 on the next edge, taking priority over a same-cycle increment.

Reset
REQ-027 SHALL, on reset=0, immediately clear synchronizers, FSMs (to IDLE), cnt, traffic_A/B=0 and veh_cnt_A/B=0, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation (any state), drop outputs asynchronously with no hold period.
REQ-029 SHALL, after reset deassertion, evaluate normally from the first rising edge of clk.

Configuration
REQ-030 SHALL compile the vehicle counters (REQ-024..026) only when macro TRAFFIC_COUNT_EN is defined.
REQ-031 SHALL, without TRAFFIC_COUNT_EN, tie veh_cnt_A/B to constant 0, ignore cnt_clr and leave traffic_A/B behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, TRAFFIC_COUNT_EN defined)
REQ-032 SHALL cover reset: reset=0 with raw inputs high -> all outputs 0; release with raws low -> outputs remain 0 for 20 cycles.
REQ-033 SHALL cover glitch rejection: sensor_A_raw high for 3 cycles -> traffic_A stays 0 and veh_cnt_A stays 0.
REQ-034 SHALL cover latency: sensor_A_raw held high -> traffic_A=1 after edge 6 and veh_cnt_A=1; raw low -> traffic_A=0 after edge 10.
REQ-035 SHALL cover gap bridging: a 5-cycle low gap while traffic_B=1 -> traffic_B stays 1 throughout and veh_cnt_B is unchanged.
REQ-036 SHALL cover simultaneous activity and reset: both raws high until both traffic outputs are 1, both raws low, then reset=0 during HOLD -> traffic_A=traffic_B=0 immediately.
REQ-037 SHALL cover the counters: 300 valid A vehicles -> veh_cnt_A=255; cnt_clr=1 coincident with a new vehicle -> veh_cnt_A=0 on the next edge.
